// File: rtl/avalon_master_pkg.sv
// Shared types and register map for the Avalon command master.
// The map describes the testbench register slave this master targets.
package avalon_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUS    = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int CTRL_ADDR      = 'h00;
    localparam int DATA_CTR_ADDR  = 'h04;
    localparam int EVENT_CTR_ADDR = 'h08;
    localparam int VERSION_ADDR   = 'h0C;
    localparam int DEBUG_ADDR     = 'h10;

    localparam int CTRL_RESET_BIT  = 0;
    localparam int CTRL_ENABLE_BIT = 1;
    localparam int CTRL_FREEZE_BIT = 2;

endpackage

// File: rtl/avalon_wait_counter.sv
// Loadable down-counter; done is high while the count sits at zero.
// Shared between the waitrequest timeout and the read-latency wait.
module avalon_wait_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/avalon_cmd_master.sv
// Single-word Avalon-MM master driven by a valid/ready command port.
// One transaction in flight; all outputs come straight from registers.
module avalon_cmd_master
    import avalon_master_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int ADDR_W       = 5,
    parameter int READ_LATENCY = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [WIDTH-1:0]  cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_read,
    output logic              master_write,
    output logic [WIDTH-1:0]  master_writedata,
    input  logic [WIDTH-1:0]  master_readdata,
    input  logic              master_waitrequest
);

    localparam int CW = 16;
    // Counter is preloaded with N-1 so done marks the Nth cycle.
    localparam logic [CW-1:0] TO_LOAD = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] RL_LOAD = CW'(READ_LATENCY - 1);

    state_t          state;
    logic            is_write;
    logic            accept;
    logic            bus_ok;
    logic            cnt_load;
    logic            cnt_dec;
    logic            cnt_done;
    logic [CW-1:0]   cnt_value;

    assign accept = (state == IDLE) && cmd_ready && cmd_valid;
    assign bus_ok = (state == BUS) && !master_waitrequest;

    always_comb begin
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        cnt_value = TO_LOAD;
        if (accept) begin
            cnt_load = 1'b1;
        end else if (bus_ok) begin
            cnt_load  = 1'b1;
            cnt_value = RL_LOAD;
        end else if (state == BUS || state == RDWAIT) begin
            cnt_dec = 1'b1;
        end
    end

    avalon_wait_counter #(.W(CW)) u_wait (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cnt_value),
        .dec        (cnt_dec),
        .done       (cnt_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            is_write         <= 1'b0;
            cmd_ready        <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_error        <= 1'b0;
            rsp_data         <= '0;
            master_read      <= 1'b0;
            master_write     <= 1'b0;
            master_address   <= '0;
            master_writedata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state            <= BUS;
                        cmd_ready        <= 1'b0;
                        is_write         <= cmd_write;
                        master_read      <= !cmd_write;
                        master_write     <= cmd_write;
                        master_address   <= cmd_address;
                        master_writedata <= cmd_wdata;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                BUS: begin
                    if (!master_waitrequest) begin
                        master_read  <= 1'b0;
                        master_write <= 1'b0;
                        if (is_write) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b0;
                            rsp_data  <= '0;
                        end else begin
                            state <= RDWAIT;
                        end
                    end else if (cnt_done) begin
                        master_read  <= 1'b0;
                        master_write <= 1'b0;
                        state        <= RESP;
                        rsp_valid    <= 1'b1;
                        rsp_error    <= 1'b1;
                        rsp_data     <= '0;
                    end
                end
                RDWAIT: begin
                    if (cnt_done) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b0;
                        rsp_data  <= master_readdata;
                    end
                end
                RESP: begin
                    // Raising cmd_ready here allows a new command right after.
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_cmd_master.sv
// Randomized and directed bench for avalon_cmd_master with a register slave
// model and a transaction-level scoreboard of data, latency and strobes.
module tb_avalon_cmd_master;

    localparam int RL = 1;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [4:0]  cmd_address = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_error;
    logic [4:0]  m_addr;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_wait;

    int total = 0;
    int bad = 0;

    avalon_cmd_master #(
        .WIDTH(32), .ADDR_W(5), .READ_LATENCY(RL), .TIMEOUT(TO)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_write          (cmd_write),
        .cmd_address        (cmd_address),
        .cmd_wdata          (cmd_wdata),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_data           (rsp_data),
        .rsp_error          (rsp_error),
        .master_address     (m_addr),
        .master_read        (m_read),
        .master_write       (m_write),
        .master_writedata   (m_wdata),
        .master_readdata    (m_rdata),
        .master_waitrequest (m_wait)
    );

    always #5 clk = ~clk;

    // Register contents before any write; VERSION reads as 20.
    function automatic logic [31:0] dflt(input logic [4:0] a);
        if (a == 5'h0C) return 32'd20;
        return ({27'd0, a} * 32'h01010101) ^ 32'hC0DE0000;
    endfunction

    // Slave: stalls stall_req cycles per transfer (or forever when stuck),
    // returns read data one cycle after acceptance, garbage otherwise.
    int          stall_req = 0;
    bit          stuck = 1'b0;
    int          seen = 0;
    bit          s_wr[32];
    logic [31:0] s_mem[32];

    assign m_wait = stuck || ((m_read || m_write) && seen < stall_req);

    always @(posedge clk) begin
        if (!(m_read || m_write)) seen <= 0;
        else if (m_wait) seen <= seen + 1;
        m_rdata <= $urandom;
        if (m_read && !m_wait)
            m_rdata <= s_wr[m_addr] ? s_mem[m_addr] : dflt(m_addr);
        if (m_write && !m_wait) begin
            s_mem[m_addr] <= m_wdata;
            s_wr[m_addr]  <= 1'b1;
        end
    end

    bit          r_wr[32];
    logic [31:0] r_val[32];

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        return r_wr[a] ? r_val[a] : dflt(a);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input bit wr, input logic [4:0] a,
                           input logic [31:0] d, input int stalls,
                           input int hold, input string tag);
        bit          to;
        int          lat_exp;
        int          strb_exp;
        int          lat;
        int          strb;
        int          w;
        bit          strb_ok;
        bit          hold_ok;
        logic [31:0] data_exp;
        logic [31:0] d0;
        logic        e0;

        to       = (stalls >= TO);
        strb_exp = to ? TO : stalls + 1;
        lat_exp  = to ? 1 + TO : (wr ? 2 + stalls : 2 + RL + stalls);
        data_exp = (to || wr) ? 32'd0 : ref_read(a);
        if (wr && !to) begin
            r_wr[a]  = 1'b1;
            r_val[a] = d;
        end

        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_ready"}, 64'(cmd_ready), 64'd1);

        cmd_valid   = 1'b1;
        cmd_write   = wr;
        cmd_address = a;
        cmd_wdata   = d;
        stall_req   = stalls;
        stuck       = to;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_write = ~wr;
        cmd_wdata = $urandom;

        lat     = 0;
        strb    = 0;
        strb_ok = 1'b1;
        for (int c = 1; c <= lat_exp + 6; c++) begin
            @(negedge clk);
            if (m_read || m_write) begin
                strb++;
                if (m_addr !== a || m_write !== wr || m_read !== !wr)
                    strb_ok = 1'b0;
                if (wr && m_wdata !== d) strb_ok = 1'b0;
            end
            if (rsp_valid) begin
                lat = c;
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(lat_exp));
        check({tag, "_strobes"}, 64'(strb), 64'(strb_exp));
        check({tag, "_strobe_sig"}, 64'(strb_ok), 64'd1);
        check({tag, "_data"}, 64'(rsp_data), 64'(data_exp));
        check({tag, "_error"}, 64'(rsp_error), 64'(to));

        d0      = rsp_data;
        e0      = rsp_error;
        hold_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_error !== e0 ||
                cmd_ready !== 1'b0 || m_read || m_write)
                hold_ok = 1'b0;
        end
        if (hold > 0) check({tag, "_hold"}, 64'(hold_ok), 64'd1);

        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        stuck     = 1'b0;
        @(negedge clk);
        check({tag, "_done"}, 64'({rsp_valid, cmd_ready}), 64'b01);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctl", 64'({cmd_ready, rsp_valid, rsp_error, m_read, m_write}), 64'd0);
        check("rst_addr", 64'(m_addr), 64'd0);
        check("rst_data", {rsp_data, m_wdata}, 64'd0);
        reset = 1'b0;

        run_cmd(1'b1, 5'h00, 32'h0000_0003, 0, 0, "wr_ctrl");
        run_cmd(1'b0, 5'h0C, 32'h0, 0, 0, "rd_version");
        run_cmd(1'b0, 5'h00, 32'h0, 4, 0, "rd_stall4");
        run_cmd(1'b0, 5'h04, 32'h0, TO, 0, "rd_timeout");
        run_cmd(1'b1, 5'h08, 32'h1234_5678, TO + 5, 0, "wr_timeout");
        run_cmd(1'b1, 5'h10, 32'hDEAD_BEEF, TO - 1, 0, "wr_stall_max");
        run_cmd(1'b0, 5'h10, 32'h0, 0, 10, "rd_hold10");
        run_cmd(1'b0, 5'h08, 32'h0, 0, 0, "rd_after_hold");

        // Reset while the read is waiting on its data.
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_write   = 1'b0;
        cmd_address = 5'h03;
        stall_req   = 0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rdw_rst_ctl", 64'({cmd_ready, rsp_valid, rsp_error, m_read, m_write}), 64'd0);
        check("rdw_rst_addr", 64'(m_addr), 64'd0);
        check("rdw_rst_data", {rsp_data, m_wdata}, 64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rdw_after", 64'({rsp_valid, cmd_ready}), 64'b01);
        run_cmd(1'b1, 5'h03, 32'hCAFE_0001, 0, 0, "wr_post_rst");
        run_cmd(1'b0, 5'h03, 32'h0, 1, 0, "rd_post_rst");

        for (int n = 0; n < 30; n++) begin
            bit          wr;
            logic [4:0]  a;
            logic [31:0] d;
            int          st;
            wr = 1'($urandom_range(0, 1));
            a  = 5'($urandom_range(0, 31));
            d  = $urandom;
            st = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, 3);
            run_cmd(wr, a, d, st, $urandom_range(0, 2), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
